// File: rtl/tick_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_pwm_pkg
// Brief    : Shared types and default sizes for the tick-driven PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
package tick_pwm_pkg;

    // Default width of period/duty/counter, counted in ticks
    localparam int c_PERIOD_W    = 8;
    // Default depth of the div_in synchroniser (must be >= 2)
    localparam int c_SYNC_STAGES = 2;

    // Run-control state machine encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage : tick_pwm_pkg
`default_nettype wire

// File: rtl/edge_tick_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_tick_sync
// Brief    : Synchronises the divided-clock input and turns its edges into a
//            registered one-cycle tick (rising only, or both edges).
// Revision : 1.0 - initial release
// ============================================================================
module edge_tick_sync
    import tick_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = c_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic div_in,
    input  logic edge_sel,
    output logic tick
);

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   r_prev_q;
    logic                   w_prev_d;
    logic                   r_tick_q;
    logic                   w_tick_d;
    logic                   w_s;

    // Shift div_in through the synchroniser and compare the synchronised
    // level against its previous value to find edges.
    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], div_in};
        w_s      = r_sync_q[SYNC_STAGES-1];
        w_prev_d = w_s;
        w_tick_d = (w_s & ~r_prev_q) | (edge_sel & ~w_s & r_prev_q);
    end

    // Synchroniser, edge-history and tick registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_q <= '0;
            r_prev_q <= 1'b0;
            r_tick_q <= 1'b0;
        end else begin
            r_sync_q <= w_sync_d;
            r_prev_q <= w_prev_d;
            r_tick_q <= w_tick_d;
        end
    end

    assign tick = r_tick_q;

endmodule : edge_tick_sync
`default_nettype wire

// File: rtl/tick_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : tick_pwm_generator
// Brief    : PWM whose period and duty are counted in ticks derived from the
//            edges of a slow divided-clock input. Configuration arrives over a
//            valid/ready handshake and is applied only at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module tick_pwm_generator
    import tick_pwm_pkg::*;
#(
    parameter int PERIOD_W    = c_PERIOD_W,
    parameter int SYNC_STAGES = c_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                div_in,
    input  logic                edge_sel,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [PERIOD_W-1:0] cfg_duty,
    output logic                tick,
    output logic                pwm_out,
    output logic                period_done,
    output logic                running
);

    localparam logic [PERIOD_W-1:0] c_ONE = PERIOD_W'(1);

    pwm_state_e          r_state_q,       w_state_d;
    logic [PERIOD_W-1:0] r_cnt_q,         w_cnt_d;
    logic [PERIOD_W-1:0] r_act_period_q,  w_act_period_d;
    logic [PERIOD_W-1:0] r_act_duty_q,    w_act_duty_d;
    logic [PERIOD_W-1:0] r_shd_period_q,  w_shd_period_d;
    logic [PERIOD_W-1:0] r_shd_duty_q,    w_shd_duty_d;
    logic                r_pending_q,     w_pending_d;
    logic                r_loaded_q,      w_loaded_d;
    logic                r_pwm_q,         w_pwm_d;
    logic                r_period_done_q, w_period_done_d;

    logic                w_tick;
    logic                w_accept;
    logic                w_running;
    logic [PERIOD_W-1:0] w_last;
    logic                w_wrap;

    edge_tick_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_tick_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_in   (div_in),
        .edge_sel (edge_sel),
        .tick     (w_tick)
    );

    assign w_accept  = cfg_valid & ~r_pending_q;
    assign w_running = (r_state_q == RUN);
    // A programmed period of 0 behaves as 1, so the last count is then 0
    assign w_last    = (r_act_period_q == '0) ? '0 : (r_act_period_q - c_ONE);
    assign w_wrap    = (r_cnt_q == w_last);

    // Run control, config capture/promotion, tick counter and PWM compare
    always_comb begin
        w_state_d       = r_state_q;
        w_cnt_d         = r_cnt_q;
        w_act_period_d  = r_act_period_q;
        w_act_duty_d    = r_act_duty_q;
        w_shd_period_d  = r_shd_period_q;
        w_shd_duty_d    = r_shd_duty_q;
        w_pending_d     = r_pending_q;
        w_loaded_d      = r_loaded_q;
        w_period_done_d = 1'b0;
        w_pwm_d         = w_running && (r_cnt_q < r_act_duty_q);

        case (r_state_q)
            IDLE: begin
                // Nothing is running, so a new config can take effect at once
                if (w_accept) begin
                    w_act_period_d = cfg_period;
                    w_act_duty_d   = cfg_duty;
                    w_loaded_d     = 1'b1;
                end
                if (enable && r_loaded_q) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Disable wins over any tick; leave with a clean counter
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                    if (r_pending_q) begin
                        w_act_period_d = r_shd_period_q;
                        w_act_duty_d   = r_shd_duty_q;
                        w_pending_d    = 1'b0;
                    end else if (w_accept) begin
                        w_act_period_d = cfg_period;
                        w_act_duty_d   = cfg_duty;
                        w_loaded_d     = 1'b1;
                    end
                end else begin
                    if (w_accept) begin
                        w_shd_period_d = cfg_period;
                        w_shd_duty_d   = cfg_duty;
                        w_pending_d    = 1'b1;
                    end
                    if (w_tick) begin
                        w_cnt_d         = w_wrap ? '0 : (r_cnt_q + c_ONE);
                        w_period_done_d = w_wrap;
                        // Only a config pending before this cycle is promoted;
                        // one accepted on the wrap cycle waits a full period.
                        if (w_wrap && r_pending_q) begin
                            w_act_period_d = r_shd_period_q;
                            w_act_duty_d   = r_shd_duty_q;
                            w_pending_d    = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State, configuration and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q       <= IDLE;
            r_cnt_q         <= '0;
            r_act_period_q  <= '0;
            r_act_duty_q    <= '0;
            r_shd_period_q  <= '0;
            r_shd_duty_q    <= '0;
            r_pending_q     <= 1'b0;
            r_loaded_q      <= 1'b0;
            r_pwm_q         <= 1'b0;
            r_period_done_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_cnt_q         <= w_cnt_d;
            r_act_period_q  <= w_act_period_d;
            r_act_duty_q    <= w_act_duty_d;
            r_shd_period_q  <= w_shd_period_d;
            r_shd_duty_q    <= w_shd_duty_d;
            r_pending_q     <= w_pending_d;
            r_loaded_q      <= w_loaded_d;
            r_pwm_q         <= w_pwm_d;
            r_period_done_q <= w_period_done_d;
        end
    end

    assign cfg_ready   = ~r_pending_q;
    assign tick        = w_tick;
    assign pwm_out     = r_pwm_q;
    assign period_done = r_period_done_q;
    assign running     = w_running;

endmodule : tick_pwm_generator
`default_nettype wire

// File: tb/tb_tick_pwm_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_pwm_generator
// Brief    : Directed self-checking bench for tick_pwm_generator, driven by a
//            divide-by-6 model of the upstream frequency divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_pwm_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       div_in = 1'b1;
    logic       edge_sel;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic       tick;
    logic       pwm_out;
    logic       period_done;
    logic       running;

    logic       div_run = 1'b0;
    int         div_cnt = 0;
    int         tests   = 0;
    int         fails   = 0;

    tick_pwm_generator #(
        .PERIOD_W    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_in      (div_in),
        .edge_sel    (edge_sel),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .tick        (tick),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .running     (running)
    );

    always #5 clk = ~clk;

    // Divide-by-6 source: high 3 clk, low 3 clk; held high until started
    always @(negedge clk) begin
        if (div_run) begin
            div_in  = (div_cnt < 3);
            div_cnt = (div_cnt == 5) ? 0 : div_cnt + 1;
        end else begin
            div_in = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for the next period_done; counts cycles, pwm-high cycles and ticks
    // seen on the way (the final period_done cycle included). cyc=-1 on timeout.
    task automatic wait_pd(input int limit, output int cyc, output int hi, output int tk);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        hi   = 0;
        tk   = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (pwm_out) hi++;
            if (tick) tk++;
            if (period_done) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic load_idle(input logic [7:0] p, input logic [7:0] d);
        enable = 1'b0;
        step(1);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_duty   = d;
        step(1);
        cfg_valid = 1'b0;
        enable    = 1'b1;
        step(1);
    endtask

    initial begin
        int cyc, hi, tk;
        rst_n      = 1'b0;
        edge_sel   = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = 8'd0;
        cfg_duty   = 8'd0;

        // Reset state
        step(3);
        check("rst_cfg_ready",   cfg_ready,   1);
        check("rst_pwm_out",     pwm_out,     0);
        check("rst_running",     running,     0);
        check("rst_tick",        tick,        0);
        check("rst_period_done", period_done, 0);

        // div_in=1 at release gives a single tick 3 clk later
        rst_n = 1'b1;
        step(1);
        check("tick_lat1", tick, 0);
        step(1);
        check("tick_lat2", tick, 0);
        step(1);
        check("tick_lat3", tick, 1);
        step(1);
        check("tick_lat4", tick, 0);

        // Basic PWM: period 4, duty 1, rising edges only
        cfg_valid  = 1'b1;
        cfg_period = 8'd4;
        cfg_duty   = 8'd1;
        step(1);
        cfg_valid = 1'b0;
        enable    = 1'b1;
        div_run   = 1'b1;
        step(1);
        check("basic_running", running, 1);
        wait_pd(200, cyc, hi, tk);
        wait_pd(200, cyc, hi, tk);
        check("basic_period", cyc, 24);
        check("basic_high",   hi,  6);
        check("basic_ticks",  tk,  4);

        // Both edges: period 4, duty 2
        edge_sel = 1'b1;
        load_idle(8'd4, 8'd2);
        wait_pd(200, cyc, hi, tk);
        wait_pd(200, cyc, hi, tk);
        check("both_period", cyc, 12);
        check("both_high",   hi,  6);
        check("both_ticks",  tk,  4);

        // Mid-run reload: duty 1 -> 3, second offer refused while pending
        edge_sel = 1'b0;
        load_idle(8'd4, 8'd1);
        wait_pd(200, cyc, hi, tk);
        cfg_valid  = 1'b1;
        cfg_period = 8'd4;
        cfg_duty   = 8'd3;
        step(1);
        check("reload_ready_after_accept", cfg_ready, 0);
        cfg_duty = 8'd0;
        step(1);
        check("reload_second_refused_a", cfg_ready, 0);
        step(1);
        check("reload_second_refused_b", cfg_ready, 0);
        cfg_valid = 1'b0;
        wait_pd(200, cyc, hi, tk);
        check("reload_old_rest_cycles", cyc, 21);
        check("reload_old_rest_high",   hi,  3);
        check("reload_ready_after_wrap", cfg_ready, 1);
        wait_pd(200, cyc, hi, tk);
        check("reload_new_period", cyc, 24);
        check("reload_new_high",   hi,  18);

        // Boundary: duty 0 stays low
        load_idle(8'd4, 8'd0);
        wait_pd(200, cyc, hi, tk);
        wait_pd(200, cyc, hi, tk);
        check("duty0_period", cyc, 24);
        check("duty0_high",   hi,  0);

        // Boundary: duty above period stays high
        load_idle(8'd4, 8'd9);
        wait_pd(200, cyc, hi, tk);
        wait_pd(200, cyc, hi, tk);
        check("duty9_period", cyc, 24);
        check("duty9_high",   hi,  24);

        // Boundary: period 0 acts as 1, wrapping on every tick
        load_idle(8'd0, 8'd1);
        wait_pd(200, cyc, hi, tk);
        wait_pd(200, cyc, hi, tk);
        check("per0_period", cyc, 6);
        check("per0_high",   hi,  6);
        check("per0_ticks",  tk,  1);

        // Disable at cnt=2: two ticks after the wrap
        load_idle(8'd4, 8'd1);
        wait_pd(200, cyc, hi, tk);
        step(13);
        check("dis_cnt_before", dut.r_cnt_q, 2);
        enable = 1'b0;
        step(1);
        check("dis_running", running,     0);
        check("dis_cnt",     dut.r_cnt_q, 0);
        check("dis_pwm",     pwm_out,     0);

        // Reset with a config pending discards it
        enable = 1'b1;
        step(2);
        check("rstp_running", running, 1);
        cfg_valid  = 1'b1;
        cfg_period = 8'd4;
        cfg_duty   = 8'd3;
        step(1);
        cfg_valid = 1'b0;
        check("rstp_pending", cfg_ready, 0);
        rst_n = 1'b0;
        step(1);
        check("rstp_cfg_ready", cfg_ready, 1);
        check("rstp_running",   running,   0);
        check("rstp_pwm",       pwm_out,   0);
        rst_n = 1'b1;
        step(4);
        check("rstp_no_config_no_run", running,   0);
        check("rstp_ready_stays",      cfg_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_tick_pwm_generator
`default_nettype wire
